// File: rtl/pcie_ext_cap_list_walker_pkg.sv
// Shared types for the PCIe extended capability list walker: FSM states,
// walk error codes and the extended capability header layout.
package pcie_ext_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_BAD_PTR   = 2'd2,
        ERR_HOP_LIMIT = 2'd3
    } err_code_e;

    localparam logic [11:0] EXT_CAP_BASE = 12'h100;

    typedef struct packed {
        logic [11:0] next;
        logic [3:0]  version;
        logic [15:0] id;
    } ext_cap_hdr_t;

endpackage

// File: rtl/pcie_ext_cap_list_walker_if.sv
// Request/result and config-read signals of the capability list walker.
// slave = the walker itself, master = the requester plus config responder.
interface pcie_ext_cap_list_walker_if;
    import pcie_ext_cap_pkg::*;

    logic        start;
    logic [15:0] target_id;
    logic        busy;
    logic        done;
    logic        found;
    logic [11:0] found_offset;
    logic [3:0]  found_version;
    logic        error;
    err_code_e   err_code;
    logic        cfg_rd_req;
    logic [11:0] cfg_rd_addr;
    logic        cfg_rd_valid;
    logic [31:0] cfg_rd_data;

    modport slave (
        input  start, target_id, cfg_rd_valid, cfg_rd_data,
        output busy, done, found, found_offset, found_version, error, err_code,
               cfg_rd_req, cfg_rd_addr
    );

    modport master (
        output start, target_id, cfg_rd_valid, cfg_rd_data,
        input  busy, done, found, found_offset, found_version, error, err_code,
               cfg_rd_req, cfg_rd_addr
    );

endinterface

// File: rtl/pcie_ext_cap_list_walker.sv
// Walks the PCIe extended capability list from 0x100, one DWORD read per
// header, stopping on a matching ID, end of list, or a fault.
module pcie_ext_cap_list_walker
    import pcie_ext_cap_pkg::*;
#(
    parameter int MAX_HOPS       = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pcie_ext_cap_list_walker_if.slave   if_walk
);

    localparam int HOP_W = $clog2(MAX_HOPS) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [HOP_W-1:0] HOP_LAST = HOP_W'(MAX_HOPS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [15:0]      r_target;
    logic [11:0]      r_offset;
    logic [HOP_W-1:0] r_hop;
    logic [TMR_W-1:0] r_timer;
    logic [31:0]      r_hdr_raw;
    logic             r_found;
    logic [11:0]      r_found_offset;
    logic [3:0]       r_found_version;
    logic             r_error;
    err_code_e        r_err_code;

    ext_cap_hdr_t     w_hdr;
    logic             w_rd_ok;
    logic             w_tmo;
    logic             w_eval_stop;
    logic             w_eval_found;
    err_code_e        w_eval_err;

    function automatic logic [HOP_W-1:0] hop_sat_inc(input logic [HOP_W-1:0] v);
        return (&v) ? v : v + HOP_W'(1);
    endfunction

    function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : v + TMR_W'(1);
    endfunction

    assign w_hdr   = ext_cap_hdr_t'(r_hdr_raw);
    assign w_rd_ok = (r_state == ST_READ) && if_walk.cfg_rd_valid;
    assign w_tmo   = (r_state == ST_READ) && !if_walk.cfg_rd_valid && (r_timer == TMR_LAST);

    // Header checks in priority order; w_eval_stop=0 means follow the next pointer.
    always_comb begin
        w_eval_stop  = 1'b1;
        w_eval_found = 1'b0;
        w_eval_err   = ERR_NONE;
        if (r_hdr_raw == 32'hFFFF_FFFF) begin
            w_eval_err = ERR_BAD_PTR;
        end else if (r_hdr_raw == 32'h0000_0000) begin
            if (r_offset != EXT_CAP_BASE) w_eval_err = ERR_BAD_PTR;
        end else if (w_hdr.id == r_target) begin
            w_eval_found = 1'b1;
        end else if (w_hdr.next == 12'h000) begin
            w_eval_err = ERR_NONE;
        end else if ((w_hdr.next < EXT_CAP_BASE) || (w_hdr.next[1:0] != 2'b00)) begin
            w_eval_err = ERR_BAD_PTR;
        end else if (r_hop == HOP_LAST) begin
            w_eval_err = ERR_HOP_LIMIT;
        end else begin
            w_eval_stop = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (if_walk.start) w_state_nxt = ST_READ;
            ST_READ: begin
                if (w_rd_ok)    w_state_nxt = ST_EVAL;
                else if (w_tmo) w_state_nxt = ST_DONE;
            end
            ST_EVAL: w_state_nxt = w_eval_stop ? ST_DONE : ST_READ;
            ST_DONE: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        if_walk.busy          = (r_state != ST_IDLE);
        if_walk.done          = (r_state == ST_DONE);
        if_walk.cfg_rd_req    = (r_state == ST_READ);
        if_walk.cfg_rd_addr   = (r_state == ST_READ) ? r_offset : 12'h000;
        if_walk.found         = r_found;
        if_walk.found_offset  = r_found_offset;
        if_walk.found_version = r_found_version;
        if_walk.error         = r_error;
        if_walk.err_code      = r_err_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target        <= '0;
            r_offset        <= '0;
            r_hop           <= '0;
            r_timer         <= '0;
            r_hdr_raw       <= '0;
            r_found         <= 1'b0;
            r_found_offset  <= '0;
            r_found_version <= '0;
            r_error         <= 1'b0;
            r_err_code      <= ERR_NONE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (if_walk.start) begin
                        r_target        <= if_walk.target_id;
                        r_offset        <= EXT_CAP_BASE;
                        r_hop           <= '0;
                        r_timer         <= '0;
                        r_found         <= 1'b0;
                        r_found_offset  <= '0;
                        r_found_version <= '0;
                        r_error         <= 1'b0;
                        r_err_code      <= ERR_NONE;
                    end
                end
                ST_READ: begin
                    if (w_rd_ok) begin
                        r_hdr_raw <= if_walk.cfg_rd_data;
                        r_timer   <= '0;
                    end else if (w_tmo) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= tmr_sat_inc(r_timer);
                    end
                end
                ST_EVAL: begin
                    if (w_eval_stop) begin
                        r_found    <= w_eval_found;
                        r_error    <= (w_eval_err != ERR_NONE);
                        r_err_code <= w_eval_err;
                        if (w_eval_found) begin
                            r_found_offset  <= r_offset;
                            r_found_version <= w_hdr.version;
                        end
                    end else begin
                        r_offset <= w_hdr.next;
                        r_hop    <= hop_sat_inc(r_hop);
                    end
                end
                ST_DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_ext_cap_list_walker.sv
// Directed and randomized bench for the capability list walker against a
// config-space array and a list-walking reference model.
module tb_pcie_ext_cap_list_walker;
    import pcie_ext_cap_pkg::*;

    localparam int MAX_HOPS       = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem [0:1023];
    int          resp_lat = 0;
    bit          resp_en = 1'b1;
    logic        late_valid = 1'b0;
    int          wait_cnt = 0;
    int          rd_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    pcie_ext_cap_list_walker_if bus ();

    pcie_ext_cap_list_walker #(
        .MAX_HOPS       (MAX_HOPS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_walk (bus)
    );

    always #5 clk = ~clk;

    // Responder: answers after resp_lat wait cycles; late_valid pulses a stray response.
    assign bus.cfg_rd_valid = (bus.cfg_rd_req && resp_en && (wait_cnt >= resp_lat)) || late_valid;
    assign bus.cfg_rd_data  = mem[bus.cfg_rd_addr[11:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     wait_cnt <= 0;
        else if (bus.cfg_rd_req && !bus.cfg_rd_valid)   wait_cnt <= wait_cnt + 1;
        else                                            wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (bus.cfg_rd_req && bus.cfg_rd_valid) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: follow the list in mem from 0x100 applying the header rules.
    task automatic model(input logic [15:0] tgt, output bit f, output logic [11:0] off,
                         output logic [3:0] ver, output logic [1:0] ec, output int nr);
        logic [11:0] o;
        logic [31:0] h;
        int          hops;
        bit          stop;
        o = 12'h100; hops = 0; stop = 0;
        f = 0; off = 0; ver = 0; ec = 0; nr = 0;
        while (!stop) begin
            h = mem[o[11:2]];
            nr++;
            stop = 1;
            if (h == 32'hFFFF_FFFF)                       ec = 2'd2;
            else if (h == 32'h0)                          ec = (o == 12'h100) ? 2'd0 : 2'd2;
            else if (h[15:0] == tgt)                      begin f = 1; off = o; ver = h[19:16]; end
            else if (h[31:20] == 12'h0)                   ec = 2'd0;
            else if (h[31:20] < 12'h100 || h[21:20] != 0) ec = 2'd2;
            else if (hops == MAX_HOPS - 1)                ec = 2'd3;
            else begin o = h[31:20]; hops++; stop = 0; end
        end
    endtask

    task automatic run_walk(input string tag, input logic [15:0] tgt, input int lat,
                            input bit en, input bit poke);
        bit          ef;
        logic [11:0] eoff;
        logic [3:0]  ever;
        logic [1:0]  eec;
        int          enr, ecyc, cyc, r0;
        resp_lat = lat;
        resp_en  = en;
        if (en) begin
            model(tgt, ef, eoff, ever, eec, enr);
            ecyc = enr * (lat + 2) + 1;
        end else begin
            ef = 0; eoff = 0; ever = 0; eec = 2'd1; enr = 0;
            ecyc = TIMEOUT_CYCLES + 1;
        end
        r0 = rd_cnt;
        @(negedge clk);
        bus.target_id = tgt;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.target_id = 16'($urandom);
        cyc = 1;
        while (!bus.done && cyc < 400) begin
            if (poke && cyc == 2) begin
                bus.start     = 1'b1;
                bus.target_id = 16'h0001;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, ".done"},    32'(bus.done), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(ecyc));
        check({tag, ".busy"},    32'(bus.busy), 32'd1);
        check({tag, ".found"},   32'(bus.found), 32'(ef));
        check({tag, ".error"},   32'(bus.error), 32'(eec != 2'd0));
        check({tag, ".errcode"}, 32'(bus.err_code), 32'(eec));
        check({tag, ".reads"},   32'(rd_cnt - r0), 32'(enr));
        if (ef) begin
            check({tag, ".offset"},  32'(bus.found_offset), 32'(eoff));
            check({tag, ".version"}, 32'(bus.found_version), 32'(ever));
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".idle"},       32'(bus.busy), 32'd0);
        check({tag, ".found_hold"}, 32'(bus.found), 32'(ef));
        check({tag, ".ec_hold"},    32'(bus.err_code), 32'(eec));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
    endtask

    initial begin
        logic [11:0] offs [0:7];
        logic [11:0] o, nxt;
        int          len, corrupt;

        clear_mem();
        bus.start     = 1'b0;
        bus.target_id = 16'h0;

        // Reset state
        @(negedge clk);
        check("rst.busy",   32'(bus.busy), 32'd0);
        check("rst.done",   32'(bus.done), 32'd0);
        check("rst.found",  32'(bus.found), 32'd0);
        check("rst.error",  32'(bus.error), 32'd0);
        check("rst.ec",     32'(bus.err_code), 32'd0);
        check("rst.req",    32'(bus.cfg_rd_req), 32'd0);
        check("rst.addr",   32'(bus.cfg_rd_addr), 32'd0);
        check("rst.offset", 32'(bus.found_offset), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-entry chain, match on second header, with a start poke while busy
        mem[12'h100 >> 2] = {12'h148, 4'h1, 16'h0001};
        mem[12'h148 >> 2] = {12'h000, 4'h2, 16'h000B};
        run_walk("chain_hit", 16'h000B, 0, 1'b1, 1'b1);
        run_walk("chain_miss", 16'h0010, 0, 1'b1, 1'b0);
        run_walk("chain_hit_lat", 16'h000B, 2, 1'b1, 1'b0);

        mem[12'h100 >> 2] = 32'h0;
        run_walk("empty", 16'h0001, 0, 1'b1, 1'b0);

        mem[12'h100 >> 2] = {12'h0FC, 4'h1, 16'h0001};
        run_walk("bad_next", 16'h0002, 0, 1'b1, 1'b0);

        mem[12'h100 >> 2] = 32'hFFFF_FFFF;
        run_walk("all_ones", 16'h0002, 0, 1'b1, 1'b0);

        mem[12'h100 >> 2] = {12'h148, 4'h1, 16'h0001};
        mem[12'h148 >> 2] = 32'h0;
        run_walk("zero_mid", 16'h0005, 0, 1'b1, 1'b0);

        mem[12'h100 >> 2] = {12'h100, 4'h1, 16'h0001};
        run_walk("self_loop", 16'h0005, 0, 1'b1, 1'b0);

        run_walk("timeout", 16'h0005, 0, 1'b0, 1'b0);

        // Reset in the middle of a read; a stray response afterwards must be ignored
        resp_en = 1'b0;
        @(negedge clk);
        bus.target_id = 16'h000B;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst.req_before", 32'(bus.cfg_rd_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.req",  32'(bus.cfg_rd_req), 32'd0);
        check("midrst.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        late_valid = 1'b1;
        @(negedge clk);
        late_valid = 1'b0;
        @(negedge clk);
        check("late.busy",  32'(bus.busy), 32'd0);
        check("late.done",  32'(bus.done), 32'd0);
        check("late.error", 32'(bus.error), 32'd0);
        check("late.found", 32'(bus.found), 32'd0);

        // Randomized chains with optional corruption and responder latency
        for (int it = 0; it < 40; it++) begin
            clear_mem();
            len = $urandom_range(1, 5);
            o = 12'h100;
            for (int k = 0; k < len; k++) begin
                offs[k] = o;
                nxt = (k == len - 1) ? 12'h000 : 12'(o + 12'($urandom_range(1, 8) * 4));
                mem[o[11:2]] = {nxt, 4'($urandom), 16'($urandom_range(1, 6))};
                o = nxt;
            end
            corrupt = $urandom_range(0, 6);
            case (corrupt)
                0: mem[offs[len-1][11:2]][31:20] = 12'h1FE;
                1: mem[offs[len-1][11:2]][31:20] = 12'h100;
                2: mem[12'h100 >> 2] = 32'h0;
                3: mem[offs[len-1][11:2]] = 32'hFFFF_FFFF;
                4: mem[offs[len-1][11:2]][31:20] = 12'h0F0;
                default: ;
            endcase
            run_walk("rand", 16'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_ext_cap_list_walker.md
Name: pcie_ext_cap_list_walker

Overview:
- Walks the PCIe extended capability linked list in config space, starting at offset 0x100.
- Issues one DWORD config read per list entry and decodes each 32-bit header as ID[15:0], version[19:16], next[31:20].
- Stops on a matching capability ID, end of list, or a fault.
- Sits between the config-space register file read port and software-visible or firmware logic that needs a capability's offset, e.g. AER, LTR or DPC locate.

Parameters:
- MAX_HOPS, 64: maximum headers examined per walk before a loop error is declared.
- TIMEOUT_CYCLES, 256: cycles to wait for a read response before a timeout error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begins a walk; ignored while busy
- target_id  in  16  capability ID to search for; sampled on start
- busy  out  1  walk in progress
- done  out  1  one-cycle completion pulse
- found  out  1  target located; valid from done until next start
- found_offset  out  12  DWORD-aligned offset of the matching header
- found_version  out  4  capability version of the matching header
- error  out  1  walk aborted on a fault; valid from done until next start
- err_code  out  2  0 none, 1 timeout, 2 bad header/pointer, 3 hop limit
- cfg_rd_req  out  1  read request; held until response
- cfg_rd_addr  out  12  byte offset of the requested DWORD
- cfg_rd_valid  in  1  read response valid; counted only while cfg_rd_req=1
- cfg_rd_data  in  32  read response data

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- On reset, all outputs are 0, state is IDLE, and the internal offset, hop and timer registers are cleared.
- States: IDLE, READ, EVAL, DONE.
- IDLE: on start, latch target_id, set offset=0x100 and hop=0, go to READ. busy=1 from the cycle after start through the DONE cycle inclusive. On start, found, error and err_code clear to 0.
- READ: cfg_rd_req=1 and cfg_rd_addr=offset. On cfg_rd_valid (same cycle as request allowed), register the data, clear the timer, deassert the request next cycle, go to EVAL.
- READ timeout: the timer increments each cycle without valid. When timer==TIMEOUT_CYCLES-1 with no valid, set err_code=1, error=1, go to DONE. cfg_rd_valid while cfg_rd_req=0 is ignored.
- EVAL checks the header in this priority order:
  1. Header 0xFFFFFFFF: err_code=2.
  2. Header 0x00000000 at offset 0x100 (empty list): done, not found, no error. An all-zero header at any other offset is err_code=2.
  3. ID==target: found=1, found_offset=offset, found_version=hdr[19:16].
  4. next==0: end of list, not found, no error.
  5. next<0x100 or next[1:0]!=0: err_code=2.
  6. hop==MAX_HOPS-1: err_code=3.
  7. Otherwise offset=next, hop+=1, go to READ.
  - Cases 1-6 go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. found_offset, found_version and err_code hold until the next accepted start.
- Latency with a zero-wait responder: start at T, READ at T+1, EVAL at T+2. Each further hop adds 2 cycles. done rises at T+3 for a one-header walk.
- A start pulse during busy is ignored; no queueing.
- Reset mid-walk: cfg_rd_req drops immediately (async). A response arriving after reset is ignored because cfg_rd_req=0.
- Width rules: hop counter is $clog2(MAX_HOPS)+1 bits; timer is $clog2(TIMEOUT_CYCLES)+1 bits; both saturate and never wrap.

Decomposition:
- Package pcie_ext_cap_pkg holds:
  - state enum;
  - err_code enum (ERR_NONE, ERR_TIMEOUT, ERR_BAD_PTR, ERR_HOP_LIMIT);
  - constant EXT_CAP_BASE=12'h100;
  - packed struct ext_cap_hdr_t {next[11:0], version[3:0], id[15:0]} for header unpacking.
- No sub-module. The FSM, timer and hop counter stay in one module.

Test Plan:
- Chain 0x100 (ID 0x0001, next 0x148) → 0x148 (ID 0x000B, next 0x000), target 0x000B, zero-wait: done at T+5, found=1, found_offset=0x148, error=0.
- Same chain, target 0x0010: done after 2 reads, found=0, error=0; header at 0x100 = 0x00000000 → done at T+3, found=0, error=0.
- Header at 0x100 has next=0x0FC: err_code=2, error=1; header 0xFFFFFFFF → err_code=2.
- Self-loop (0x100 next=0x100), target absent, MAX_HOPS=4: exactly 4 reads, then err_code=3.
- Responder never returns valid, TIMEOUT_CYCLES=8: err_code=1 after 8 READ cycles. Second sub-case: rst_n low mid-READ → cfg_rd_req=0 immediately, then start during busy and late cfg_rd_valid are both ignored.
